noc_endpoint_node: RTL and testbench
====================================

// Module: noc_endpoint_node
// PURPOSE
//  Parametrised mesh NoC endpoint. It accepts traffic-generator requests into an injection FIFO,
//  stamps each packet with {timestamp, src, dest}, and sends packets to the local router port
//  over a valid/ready handshake. It also ejects packets arriving from the router and keeps
//  latency and traffic statistics in hardware, instead of printing them from simulation.
// PARAMETERS
//  ADDR_W     4   node address width (src/dest fields)
//  TS_W       32  timestamp/cycle-counter width
//  FIFO_DEPTH 4   injection FIFO entries, power of 2, >=2
//  CNT_W      16  width of packet/drop/misroute counters (saturating)
//  SUM_W      48  width of latency accumulator (saturating)
//  Derived: PKT_W = TS_W + 2*ADDR_W; packet = {ts[PKT_W-1:2*ADDR_W], src[2*ADDR_W-1:ADDR_W], dest[ADDR_W-1:0]}
// PORTS
//  clk            in   1       clock, all logic on posedge
//  rst            in   1       reset; asynchronous and active-high
//  ctr            in   TS_W    global free-running cycle counter
//  node_addr      in   ADDR_W  this node's address (static after reset)
//  gen_valid      in   1       traffic generator requests one injection this cycle
//  gen_dest       in   ADDR_W  destination of the requested packet
//  out_valid      out  1       injection packet available to router
//  out_packet     out  PKT_W   head-of-FIFO packet
//  out_ready      in   1       router accepts out_packet this cycle
//  in_valid       in   1       router delivers a packet to this node
//  in_packet      in   PKT_W   delivered packet
//  tx_count       out  CNT_W   packets handed to router
//  rx_count       out  CNT_W   packets ejected with dest == node_addr
//  drop_count     out  CNT_W   generator requests lost to a full FIFO
//  misroute_count out  CNT_W   ejected packets with dest != node_addr
//  lat_last       out  TS_W    latency of most recent good ejection
//  lat_max        out  TS_W    maximum latency seen
//  lat_sum        out  SUM_W   sum of latencies (for mean = lat_sum/rx_count)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FIFO empty; out_valid=0; out_packet=0.
//   - All counters, lat_last, lat_max and lat_sum are 0.
//   - Reset mid-operation discards all queued packets; nothing is replayed.
//  Injection:
//   - Push when gen_valid && (!full || pop this cycle).
//   - Entry = {ctr, node_addr, gen_dest}, captured at the push edge.
//   - gen_valid while full with no pop: request dropped, drop_count+1.
//   - Push-to-out_valid latency is 1 cycle (entry written at edge, visible after it).
//   - out_valid = !empty; out_packet = FIFO head, combinational from storage.
//   - Pop/transfer on out_valid && out_ready; tx_count+1 on the same edge.
//   - While out_valid && !out_ready, out_packet holds stable.
//   - Simultaneous push and pop on an empty FIFO: the push lands and the pop is ignored (no bypass).
//   - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from MSB compare; pointers wrap naturally.
//   - gen_dest == node_addr is legal and queued normally (the router loops it back).
//  Ejection (no backpressure; every in_valid is consumed on its edge):
//   - If in_packet dest == node_addr:
//     - lat = ctr - in_packet.ts, modulo 2^TS_W, so ctr wrap yields the correct small value.
//     - lat_last <= lat; lat_max <= max(lat_max, lat); lat_sum += lat; rx_count+1.
//   - Else: misroute_count+1; latency registers unchanged.
//  Arithmetic:
//   - All counters saturate at all-ones and never wrap.
//   - lat_sum saturates at 2^SUM_W-1; lat is zero-extended before the add.
//  Concurrency:
//   - Injection and ejection are independent; same-cycle tx, rx and drop all update.
// TESTING
//  1 Reset then idle 10 cycles -> out_valid=0, all stats 0; assert rst mid-burst -> FIFO empties immediately.
//  2 node_addr=5, out_ready=1, gen_valid at ctr=100, dest=9 -> next cycle out_packet={100,4'd5,4'd9}, tx_count=1.
//  3 out_ready=0, 6 requests, DEPTH=4 -> 4 queued in order, drop_count=2; release -> 4 pops, original order.
//  4 FIFO full, out_ready=1 and gen_valid same cycle -> push accepted, drop_count unchanged.
//  5 node_addr=5: eject ts=90 at ctr=100, then ts=97 at ctr=100 -> lat_last=3, lat_max=10, lat_sum=13, rx_count=2.
//  6 Eject ts=32'hFFFF_FFFE at ctr=3 -> lat=5; eject dest=7 -> misroute_count+1, latency regs unchanged.

Source files
------------

// File: rtl/noc_endpoint_node.sv
// noc_endpoint_node: mesh NoC endpoint with an injection FIFO, an ejection path and
// hardware-kept traffic and latency statistics.
module noc_endpoint_node #(
  parameter int ADDR_W = 4,
  parameter int TS_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int SUM_W = 48,
  localparam int PKT_W = TS_W + 2 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TS_W-1:0]   ctr,
  input  logic [ADDR_W-1:0] node_addr,
  input  logic              gen_valid,
  input  logic [ADDR_W-1:0] gen_dest,
  output logic              out_valid,
  output logic [PKT_W-1:0]  out_packet,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [PKT_W-1:0]  in_packet,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  misroute_count,
  output logic [TS_W-1:0]   lat_last,
  output logic [TS_W-1:0]   lat_max,
  output logic [SUM_W-1:0]  lat_sum
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic empty, full, pop, push, drop, rx_good, rx_bad, unused_src;
  logic [TS_W-1:0] lat;
  logic [SUM_W:0] sum_ext;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign out_valid = !empty;
  assign out_packet = empty ? '0 : mem[rd_ptr[PW-1:0]];
  assign pop = out_valid && out_ready;
  assign push = gen_valid && (!full || pop);
  assign drop = gen_valid && !push;
  assign rx_good = in_valid && (in_packet[ADDR_W-1:0] == node_addr);
  assign rx_bad = in_valid && (in_packet[ADDR_W-1:0] != node_addr);
  assign lat = ctr - in_packet[PKT_W-1:2*ADDR_W];
  assign sum_ext = {1'b0, lat_sum} + {{(SUM_W + 1 - TS_W){1'b0}}, lat};
  assign unused_src = ^in_packet[2*ADDR_W-1:ADDR_W];
  // Storage needs no reset: out_packet is masked while the FIFO is empty.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[PW-1:0]] <= {ctr, node_addr, gen_dest};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_count <= '0;
      rx_count <= '0;
      drop_count <= '0;
      misroute_count <= '0;
      lat_last <= '0;
      lat_max <= '0;
      lat_sum <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) tx_count <= sat_inc(tx_count);
      if (drop) drop_count <= sat_inc(drop_count);
      if (rx_bad) misroute_count <= sat_inc(misroute_count);
      if (rx_good) begin
        rx_count <= sat_inc(rx_count);
        lat_last <= lat;
        lat_max <= lat > lat_max ? lat : lat_max;
        lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      end
    end
endmodule

// File: tb/tb_noc_endpoint_node.sv
// tb_noc_endpoint_node: directed checks of injection, ejection, statistics and reset.
module tb_noc_endpoint_node;
  logic clk = 0, rst = 1;
  logic [31:0] ctr = 0;
  logic [3:0] node_addr = 5, gen_dest = 0;
  logic gen_valid = 0, out_ready = 0, in_valid = 0;
  logic out_valid;
  logic [39:0] out_packet, in_packet = 0;
  logic [15:0] tx_count, rx_count, drop_count, misroute_count;
  logic [31:0] lat_last, lat_max;
  logic [47:0] lat_sum;
  int checks = 0, errors = 0;
  noc_endpoint_node dut (
    .clk(clk), .rst(rst), .ctr(ctr), .node_addr(node_addr),
    .gen_valid(gen_valid), .gen_dest(gen_dest),
    .out_valid(out_valid), .out_packet(out_packet), .out_ready(out_ready),
    .in_valid(in_valid), .in_packet(in_packet),
    .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count),
    .misroute_count(misroute_count), .lat_last(lat_last), .lat_max(lat_max),
    .lat_sum(lat_sum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [39:0] pkt(input logic [31:0] ts, input logic [3:0] s, input logic [3:0] d);
    return {ts, s, d};
  endfunction
  initial begin
    tick();
    tick();
    rst = 0;
    repeat (10) tick();
    chk("idle_valid", out_valid, 0);
    chk("idle_pkt", out_packet, 0);
    chk("idle_tx", tx_count, 0);
    chk("idle_rx", rx_count, 0);
    chk("idle_drop", drop_count, 0);
    chk("idle_mis", misroute_count, 0);
    chk("idle_lat", {lat_last, lat_max}, 0);
    chk("idle_sum", lat_sum, 0);
    // single injection
    out_ready = 1; gen_valid = 1; gen_dest = 9; ctr = 100;
    tick();
    gen_valid = 0;
    chk("inj_valid", out_valid, 1);
    chk("inj_pkt", out_packet, pkt(100, 5, 9));
    tick();
    chk("inj_tx", tx_count, 1);
    chk("inj_empty", out_valid, 0);
    // overflow with router stalled
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      gen_valid = 1; gen_dest = 4'(i + 1); ctr = 200 + i;
      tick();
    end
    gen_valid = 0;
    chk("ovf_drop", drop_count, 2);
    chk("ovf_hold", out_packet, pkt(200, 5, 1));
    tick();
    chk("ovf_hold2", out_packet, pkt(200, 5, 1));
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), out_packet, pkt(200 + i, 5, 4'(i + 1)));
      tick();
    end
    chk("ovf_tx", tx_count, 5);
    chk("ovf_empty", out_valid, 0);
    // push into a full FIFO while it pops
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      gen_valid = 1; gen_dest = 4'(10 + i); ctr = 300 + i;
      tick();
    end
    out_ready = 1; gen_dest = 14; ctr = 310;
    tick();
    gen_valid = 0;
    chk("full_drop", drop_count, 2);
    chk("full_tx", tx_count, 6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_pop%0d", i), out_packet,
          i < 3 ? pkt(301 + i, 5, 4'(11 + i)) : pkt(310, 5, 14));
      tick();
    end
    chk("full_tx2", tx_count, 10);
    // ejection and latency
    in_valid = 1; in_packet = pkt(90, 3, 5); ctr = 100;
    tick();
    in_packet = pkt(97, 3, 5);
    tick();
    chk("ej_last", lat_last, 3);
    chk("ej_max", lat_max, 10);
    chk("ej_sum", lat_sum, 13);
    chk("ej_rx", rx_count, 2);
    in_packet = pkt(32'hFFFF_FFFE, 3, 5); ctr = 3;
    tick();
    chk("wrap_last", lat_last, 5);
    chk("wrap_sum", lat_sum, 18);
    in_packet = pkt(50, 3, 7); ctr = 60;
    tick();
    in_valid = 0;
    chk("mis_cnt", misroute_count, 1);
    chk("mis_lat", {lat_last, lat_max}, {32'd5, 32'd10});
    chk("mis_sum", lat_sum, 18);
    chk("mis_rx", rx_count, 3);
    // reset mid-burst
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      gen_valid = 1; gen_dest = 2; ctr = 400 + i;
      tick();
    end
    gen_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pkt", out_packet, 0);
    chk("rst_stats", {tx_count, rx_count, drop_count, misroute_count}, 0);
    chk("rst_sum", lat_sum, 0);
    tick();
    rst = 0; out_ready = 1;
    repeat (3) tick();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_tx", tx_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
